// File: rtl/wall_follower_ctrl.sv
// Wall-following robot controller: tick generator, per-sensor debounce, side-selectable
// follow FSM with registered motor outputs and a rotation watchdog that parks in STUCK.
module wall_follower_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned ROT_MAX  = 8,
  parameter int unsigned CNT_W    = 8
) (
  input  logic       Clock,
  input  logic       Resetn,
  input  logic       Enable,
  input  logic       Head,
  input  logic       Left,
  input  logic       Right,
  input  logic       WallSide,
  input  logic       ClearStuck,
  output logic       Front,
  output logic       Rotate,
  output logic       RotDir,
  output logic       Stuck,
  output logic [1:0] State,
  output logic       Tick
);

  localparam int unsigned TickW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] DebLim   = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] RotLim   = CNT_W'(ROT_MAX);

  localparam logic [1:0] StSearch = 2'b00;
  localparam logic [1:0] StFollow = 2'b01;
  localparam logic [1:0] StRotate = 2'b10;
  localparam logic [1:0] StStuck  = 2'b11;

  logic [TickW-1:0]            tick_cnt_q, tick_cnt_d;
  logic                        tick;
  logic [2:0]                  raw;
  logic [2:0]                  filt_q, filt_d;
  logic [2:0][CNT_W-1:0]       deb_cnt_q, deb_cnt_d;
  logic                        ws_q, ws_d;
  logic [1:0]                  state_q, state_d;
  logic                        front_q, front_d;
  logic                        rotate_q, rotate_d;
  logic                        rot_dir_q, rot_dir_d;
  logic [CNT_W-1:0]            rot_cnt_q, rot_cnt_d;
  logic [CNT_W-1:0]            rot_inc;
  logic                        h, s, away, toward;

  assign tick = Enable && (tick_cnt_q == TickLast);

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    if (Enable) begin
      tick_cnt_d = tick ? '0 : tick_cnt_q + TickW'(1);
    end
  end

  // Bit 0 = Left, 1 = Right, 2 = Head.
  assign raw = {Head, Right, Left};

  always_comb begin
    filt_d    = filt_q;
    deb_cnt_d = deb_cnt_q;
    for (int i = 0; i < 3; i++) begin
      if (tick) begin
        if (raw[i] != filt_q[i]) begin
          if ((deb_cnt_q[i] + CNT_W'(1)) == DebLim) begin
            filt_d[i]    = raw[i];
            deb_cnt_d[i] = '0;
          end else begin
            deb_cnt_d[i] = deb_cnt_q[i] + CNT_W'(1);
          end
        end else begin
          deb_cnt_d[i] = '0;
        end
      end
    end
  end

  // The decision on a tick sees the filter values and side latched on that same tick.
  assign ws_d   = (tick && (state_q == StSearch)) ? WallSide : ws_q;
  assign h      = filt_d[2];
  assign s      = ws_d ? filt_d[1] : filt_d[0];
  assign away   = ~ws_d;
  assign toward = ws_d;
  assign rot_inc = rot_cnt_q + CNT_W'(1);

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    rotate_d  = rotate_q;
    rot_dir_d = rot_dir_q;
    rot_cnt_d = rot_cnt_q;
    if ((state_q == StStuck) && ClearStuck) begin
      state_d   = StSearch;
      front_d   = 1'b0;
      rotate_d  = 1'b0;
      rot_cnt_d = '0;
    end else if (!Enable) begin
      front_d  = 1'b0;
      rotate_d = 1'b0;
    end else if (tick) begin
      unique case (state_q)
        StSearch: begin
          if (h) begin
            state_d   = StRotate;
            front_d   = 1'b0;
            rotate_d  = 1'b1;
            rot_dir_d = away;
            rot_cnt_d = '0;
          end else begin
            state_d  = s ? StFollow : StSearch;
            front_d  = 1'b1;
            rotate_d = 1'b0;
          end
        end
        StFollow: begin
          unique case ({h, s})
            2'b01: begin
              front_d  = 1'b1;
              rotate_d = 1'b0;
            end
            2'b00: begin
              state_d   = StSearch;
              front_d   = 1'b0;
              rotate_d  = 1'b1;
              rot_dir_d = toward;
            end
            2'b10: begin
              state_d   = StSearch;
              front_d   = 1'b0;
              rotate_d  = 1'b1;
              rot_dir_d = away;
            end
            default: begin
              state_d   = StRotate;
              front_d   = 1'b0;
              rotate_d  = 1'b1;
              rot_dir_d = away;
              rot_cnt_d = '0;
            end
          endcase
        end
        StRotate: begin
          if ({h, s} == 2'b01) begin
            state_d   = StFollow;
            front_d   = 1'b1;
            rotate_d  = 1'b0;
            rot_cnt_d = '0;
          end else begin
            rot_cnt_d = rot_inc;
            front_d   = 1'b0;
            if (rot_inc == RotLim) begin
              state_d  = StStuck;
              rotate_d = 1'b0;
            end else begin
              rotate_d = 1'b1;
            end
          end
        end
        default: begin
          front_d  = 1'b0;
          rotate_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      tick_cnt_q <= '0;
      filt_q     <= '0;
      deb_cnt_q  <= '0;
      ws_q       <= 1'b0;
      state_q    <= StSearch;
      front_q    <= 1'b0;
      rotate_q   <= 1'b0;
      rot_dir_q  <= 1'b0;
      rot_cnt_q  <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      filt_q     <= filt_d;
      deb_cnt_q  <= deb_cnt_d;
      ws_q       <= ws_d;
      state_q    <= state_d;
      front_q    <= front_d;
      rotate_q   <= rotate_d;
      rot_dir_q  <= rot_dir_d;
      rot_cnt_q  <= rot_cnt_d;
    end
  end

  assign Front  = front_q;
  assign Rotate = rotate_q;
  assign RotDir = rot_dir_q;
  assign Stuck  = (state_q == StStuck);
  assign State  = state_q;
  assign Tick   = tick;

endmodule

// File: tb/tb_wall_follower_ctrl.sv
// Bench for wall_follower_ctrl: stimulus queues the expected output tuple per decision tick and
// a monitor compares after every Tick edge; out-of-tick behaviour is checked inline.
module tb_wall_follower_ctrl;

  logic       Clock;
  logic       Resetn;
  logic       Enable;
  logic       Head;
  logic       Left;
  logic       Right;
  logic       WallSide;
  logic       ClearStuck;
  logic       Front;
  logic       Rotate;
  logic       RotDir;
  logic       Stuck;
  logic [1:0] State;
  logic       Tick;

  typedef struct packed {
    logic [1:0] state;
    logic       front;
    logic       rotate;
    logic       rot_dir;
    logic       stuck;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  wall_follower_ctrl #(
    .TICK_DIV(4),
    .DEBOUNCE(3),
    .ROT_MAX (8),
    .CNT_W   (8)
  ) dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .Enable    (Enable),
    .Head      (Head),
    .Left      (Left),
    .Right     (Right),
    .WallSide  (WallSide),
    .ClearStuck(ClearStuck),
    .Front     (Front),
    .Rotate    (Rotate),
    .RotDir    (RotDir),
    .Stuck     (Stuck),
    .State     (State),
    .Tick      (Tick)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  function automatic exp_t mk(input logic [1:0] st, input logic f, input logic r,
                              input logic d, input logic s);
    return {st, f, r, d, s};
  endfunction

  function automatic logic [5:0] outs();
    return {State, Front, Rotate, RotDir, Stuck};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: after each edge that closed a Tick cycle, compare against the oldest expectation.
  initial begin : monitor
    exp_t e;
    int   n;
    n = 0;
    forever begin
      @(negedge Clock);
      #2;
      if (Tick && Resetn) begin
        @(posedge Clock);
        #1;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check($sformatf("tick%0d {State,Front,Rotate,RotDir,Stuck}", n), outs(), e);
          check($sformatf("tick%0d front_rotate_exclusive", n), Front & Rotate, 0);
          n++;
        end
      end
    end
  end

  task automatic wait_tick();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 16 && !seen; i++) begin
      #1;
      if (Tick) seen = 1'b1;
      @(negedge Clock);
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL tick_timeout: got no Tick, expected one within 16 cycles");
    end
  endtask

  task automatic step(input logic h, input logic l, input logic r, input logic ws, input exp_t e);
    Head     = h;
    Left     = l;
    Right    = r;
    WallSide = ws;
    exp_q.push_back(e);
    wait_tick();
  endtask

  initial begin : timeout
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish before 100000");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    exp_t s_f, fol_f, rot_a, stk;
    s_f   = mk(2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    fol_f = mk(2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    rot_a = mk(2'b10, 1'b0, 1'b1, 1'b1, 1'b0);
    stk   = mk(2'b11, 1'b0, 1'b0, 1'b1, 1'b1);

    Resetn = 1'b0; Enable = 1'b0; Head = 1'b0; Left = 1'b0; Right = 1'b0;
    WallSide = 1'b0; ClearStuck = 1'b0;
    repeat (2) @(negedge Clock);
    check("reset_outputs", outs(), 0);
    check("reset_tick", Tick, 0);
    Resetn = 1'b1;
    Enable = 1'b1;

    // Tick cadence with all sensors clear; first two ticks drive forward in SEARCH.
    exp_q.push_back(s_f);
    exp_q.push_back(s_f);
    for (int c = 0; c < 8; c++) begin
      #1;
      check($sformatf("tick_cadence_cycle%0d", c), Tick, ((c % 4) == 3));
      @(negedge Clock);
    end

    // Left wall appears: debounced over three ticks, then FOLLOW.
    step(1'b0, 1'b1, 1'b0, 1'b0, s_f);
    step(1'b0, 1'b1, 1'b0, 1'b0, s_f);
    step(1'b0, 1'b1, 1'b0, 1'b0, fol_f);
    // Two-tick dropout must be filtered out.
    step(1'b0, 1'b0, 1'b0, 1'b0, fol_f);
    step(1'b0, 1'b0, 1'b0, 1'b0, fol_f);
    step(1'b0, 1'b1, 1'b0, 1'b0, fol_f);

    // Obstacle ahead with wall on the left: rotate clockwise (away).
    step(1'b1, 1'b1, 1'b0, 1'b0, fol_f);
    step(1'b1, 1'b1, 1'b0, 1'b0, fol_f);
    step(1'b1, 1'b1, 1'b0, 1'b0, rot_a);
    repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0, rot_a);

    // Pause mid-rotation: motors stop, state and direction hold, no ticks.
    Enable = 1'b0;
    @(posedge Clock);
    #1;
    check("disable_front_rotate", {Front, Rotate}, 2'b00);
    check("disable_state_dir_stuck", {State, RotDir, Stuck}, 4'b1010);
    repeat (4) begin
      @(negedge Clock);
      #1;
      check("disable_no_tick", Tick, 0);
    end
    check("disable_state_frozen", State, 2'b10);
    @(negedge Clock);
    Enable = 1'b1;

    // Rotation count resumes from 3: four more rotating ticks, then STUCK on the eighth.
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, rot_a);
    step(1'b1, 1'b1, 1'b0, 1'b0, stk);
    step(1'b1, 1'b1, 1'b0, 1'b0, stk);

    // Clear from STUCK on a non-tick edge.
    check("pre_clear_no_tick", Tick, 0);
    ClearStuck = 1'b1;
    @(posedge Clock);
    #1;
    check("clear_stuck", {State, Front, Rotate, Stuck}, 5'b00000);
    @(negedge Clock);
    ClearStuck = 1'b0;

    // Filters were kept: obstacle still seen, so straight back into ROTATE.
    step(1'b1, 1'b1, 1'b0, 1'b0, rot_a);
    step(1'b1, 1'b1, 1'b0, 1'b0, rot_a);

    // Asynchronous reset between clock edges.
    #3;
    Resetn = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 0);
    Head = 1'b0; Left = 1'b0; Enable = 1'b0;
    @(negedge Clock);
    check("reset_held_outputs", outs(), 0);
    Resetn = 1'b1;
    Enable = 1'b1;

    // Right-wall following.
    step(1'b0, 1'b0, 1'b1, 1'b1, s_f);
    step(1'b0, 1'b0, 1'b1, 1'b1, s_f);
    step(1'b0, 1'b0, 1'b1, 1'b1, fol_f);
    // WallSide flips while following: ignored.
    step(1'b0, 1'b0, 1'b1, 1'b0, fol_f);
    step(1'b0, 1'b0, 1'b1, 1'b0, fol_f);
    // Right wall lost: corner turn toward the wall (clockwise), back to SEARCH.
    step(1'b0, 1'b0, 1'b0, 1'b0, fol_f);
    step(1'b0, 1'b0, 1'b0, 1'b0, fol_f);
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(2'b00, 1'b0, 1'b1, 1'b1, 1'b0));
    step(1'b0, 1'b0, 1'b0, 1'b0, mk(2'b00, 1'b1, 1'b0, 1'b1, 1'b0));

    repeat (2) @(negedge Clock);
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
